// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, two asynchronous read ports,
// optional write-to-read bypass, optional hardwired-zero register 0 and a sequential clear engine.
module regfile_mp #(
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 16,
  parameter  int BYPASS  = 1,
  parameter  int R0_ZERO = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_ready
);

  localparam logic              USE_BYPASS = (BYPASS != 0);
  localparam logic              USE_ZERO   = (R0_ZERO != 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  // Handshake: a write on port N is taken at the rising edge where weN=1 and
  // wr_ready=1; with wr_ready=0 the write is dropped, never held over.
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wen0;
  logic                wen1;

  assign clr_busy = (state == CLEAR);
  assign wr_ready = ~clr_busy;

  // Effective write enables already fold in the ready gate and the zero-register discard.
  assign wen0 = we0 & wr_ready & ~(USE_ZERO & (wa0 == '0));
  assign wen1 = we1 & wr_ready & ~(USE_ZERO & (wa1 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (clr_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) state_nxt = IDLE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == CLEAR) mem[cnt] <= '0;
      if (wen0)           mem[wa0] <= wd0;
      if (wen1)           mem[wa1] <= wd1;
    end
  end

  always_comb begin
    rd0 = mem[ra0];
    if (USE_BYPASS && wen0 && (wa0 == ra0)) rd0 = wd0;
    if (USE_BYPASS && wen1 && (wa1 == ra0)) rd0 = wd1;
    if (USE_ZERO && (ra0 == '0))            rd0 = '0;
    if (!rst_n)                             rd0 = '0;
  end

  always_comb begin
    rd1 = mem[ra1];
    if (USE_BYPASS && wen0 && (wa0 == ra1)) rd1 = wd0;
    if (USE_BYPASS && wen1 && (wa1 == ra1)) rd1 = wd1;
    if (USE_ZERO && (ra1 == '0))            rd1 = '0;
    if (!rst_n)                             rd1 = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations share stimulus; expectations are
// queued by the driver and compared by a negedge monitor.
module tb_regfile_mp;

  localparam int S_RD0_A  = 0;
  localparam int S_RD1_A  = 1;
  localparam int S_BUSY_A = 2;
  localparam int S_RDY_A  = 3;
  localparam int S_RD0_B  = 4;
  localparam int S_RD0_C  = 5;
  localparam int S_RD1_C  = 6;
  localparam int S_BUSY_C = 7;
  localparam int S_RDY_C  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we0, we1, clr_req;
  logic [3:0] wa0, wa1, ra0, ra1;
  logic [7:0] wd0, wd1;

  logic [7:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;
  logic       busy_a, rdy_a, busy_b, rdy_b, busy_c, rdy_c;

  logic       sample;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] exp_q[$];
  int         sel_q[$];
  string      name_q[$];

  logic [7:0] old_v [16];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(8), .DEPTH(16), .BYPASS(1), .R0_ZERO(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0_a), .ra1(ra1), .rd1(rd1_a),
    .clr_req(clr_req), .clr_busy(busy_a), .wr_ready(rdy_a)
  );

  regfile_mp #(.DATA_W(8), .DEPTH(16), .BYPASS(0), .R0_ZERO(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0_b), .ra1(ra1), .rd1(rd1_b),
    .clr_req(clr_req), .clr_busy(busy_b), .wr_ready(rdy_b)
  );

  regfile_mp #(.DATA_W(8), .DEPTH(16), .BYPASS(1), .R0_ZERO(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0_c), .ra1(ra1), .rd1(rd1_c),
    .clr_req(clr_req), .clr_busy(busy_c), .wr_ready(rdy_c)
  );

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      S_RD0_A:  return rd0_a;
      S_RD1_A:  return rd1_a;
      S_BUSY_A: return {7'd0, busy_a};
      S_RDY_A:  return {7'd0, rdy_a};
      S_RD0_B:  return rd0_b;
      S_RD0_C:  return rd0_c;
      S_RD1_C:  return rd1_c;
      S_BUSY_C: return {7'd0, busy_c};
      S_RDY_C:  return {7'd0, rdy_c};
      default:  return 8'hxx;
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current sample point.
  always @(negedge clk) begin
    if (sample) begin
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        logic [7:0] act;
        int         s;
        string      n;
        e   = exp_q.pop_front();
        s   = sel_q.pop_front();
        n   = name_q.pop_front();
        act = pick(s);
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", n, act, e);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [7:0] v, input string name);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now();
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
  endtask

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample = 1'b0; clr_req = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra0 = '0; ra1 = '0;

    // Reads are forced to zero while reset is held, even with a matching write active.
    #2;
    we1 = 1'b1; wa1 = 4'd2; wd1 = 8'h77; ra0 = 4'd2; ra1 = 4'd2;
    expect_v(S_RD0_A, 8'h00, "rst_bypass_rd0_a");
    expect_v(S_RD1_C, 8'h00, "rst_bypass_rd1_c");
    expect_v(S_BUSY_A, 8'h00, "rst_busy_a");
    expect_v(S_RDY_A, 8'h01, "rst_ready_a");
    check_now();
    we1 = 1'b0;
    tick();
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      tick();
      ra0 = 4'(a); ra1 = 4'(15 - a);
      expect_v(S_RD0_A, 8'h00, $sformatf("reset_rd0_a_%0d", a));
      expect_v(S_RD1_A, 8'h00, $sformatf("reset_rd1_a_%0d", 15 - a));
      expect_v(S_RD0_B, 8'h00, $sformatf("reset_rd0_b_%0d", a));
      check_now();
    end
    expect_v(S_BUSY_A, 8'h00, "idle_busy_a");
    expect_v(S_RDY_A, 8'h01, "idle_ready_a");
    check_now();

    // Dual write to different addresses.
    tick();
    we0 = 1'b1; wa0 = 4'd3; wd0 = 8'h5A; we1 = 1'b1; wa1 = 4'd7; wd1 = 8'hC3;
    tick();
    we0 = 1'b0; we1 = 1'b0; ra0 = 4'd3; ra1 = 4'd7;
    expect_v(S_RD0_A, 8'h5A, "dual_rd0_a");
    expect_v(S_RD1_A, 8'hC3, "dual_rd1_a");
    expect_v(S_RD0_B, 8'h5A, "dual_rd0_b");
    expect_v(S_RD1_C, 8'hC3, "dual_rd1_c");
    check_now();

    // Collision on address 9: port 1 wins in storage and in bypass.
    tick();
    we0 = 1'b1; wa0 = 4'd9; wd0 = 8'h11; we1 = 1'b1; wa1 = 4'd9; wd1 = 8'h22;
    ra0 = 4'd9; ra1 = 4'd9;
    expect_v(S_RD0_A, 8'h22, "coll_bypass_rd0_a");
    expect_v(S_RD1_A, 8'h22, "coll_bypass_rd1_a");
    expect_v(S_RD0_B, 8'h00, "coll_nobypass_rd0_b");
    check_now();
    tick();
    we0 = 1'b0; we1 = 1'b0;
    expect_v(S_RD0_A, 8'h22, "coll_rd0_a");
    expect_v(S_RD0_B, 8'h22, "coll_rd0_b");
    expect_v(S_RD1_C, 8'h22, "coll_rd1_c");
    check_now();

    // Same-cycle bypass on both write ports.
    tick();
    we1 = 1'b1; wa1 = 4'd4; wd1 = 8'h99; we0 = 1'b1; wa0 = 4'd6; wd0 = 8'h66;
    ra0 = 4'd4; ra1 = 4'd6;
    expect_v(S_RD0_A, 8'h99, "byp_rd0_a");
    expect_v(S_RD1_A, 8'h66, "byp_port0_rd1_a");
    expect_v(S_RD0_B, 8'h00, "byp_old_rd0_b");
    expect_v(S_RD0_C, 8'h99, "byp_rd0_c");
    check_now();
    tick();
    we0 = 1'b0; we1 = 1'b0;
    expect_v(S_RD0_B, 8'h99, "byp_after_rd0_b");
    expect_v(S_RD1_A, 8'h66, "byp_after_rd1_a");
    check_now();

    // Register 0 writes: stored normally, discarded on the zero-register instance.
    tick();
    we0 = 1'b1; wa0 = 4'd0; wd0 = 8'hAB; ra0 = 4'd0;
    expect_v(S_RD0_A, 8'hAB, "r0_byp_rd0_a");
    expect_v(S_RD0_C, 8'h00, "r0_byp_rd0_c");
    check_now();
    tick();
    we0 = 1'b0;
    expect_v(S_RD0_A, 8'hAB, "r0_rd0_a");
    expect_v(S_RD0_B, 8'hAB, "r0_rd0_b");
    expect_v(S_RD0_C, 8'h00, "r0_rd0_c");
    check_now();

    // Fill every entry with addr+0x10, two entries per edge.
    for (int i = 0; i < 8; i++) begin
      tick();
      we0 = 1'b1; wa0 = 4'(2 * i);     wd0 = 8'(2 * i + 16);
      we1 = 1'b1; wa1 = 4'(2 * i + 1); wd1 = 8'(2 * i + 17);
    end
    for (int a = 0; a < 16; a++) old_v[a] = 8'(a + 16);
    old_v[5] = 8'h55;

    // Clear request cycle still accepts a write (address 5 := 0x55).
    tick();
    we1 = 1'b0; we0 = 1'b1; wa0 = 4'd5; wd0 = 8'h55; clr_req = 1'b1;
    expect_v(S_BUSY_A, 8'h00, "clrreq_busy_a");
    expect_v(S_RDY_A, 8'h01, "clrreq_ready_a");
    check_now();
    tick();
    clr_req = 1'b0; we0 = 1'b0;

    for (int j = 0; j < 16; j++) begin
      ra0 = 4'(j);
      ra1 = (j == 0 || j == 10) ? 4'd15 : 4'(j - 1);
      clr_req = (j == 3);
      we0 = (j == 10); wa0 = 4'd15; wd0 = 8'hFF;
      expect_v(S_BUSY_A, 8'h01, $sformatf("sweep%0d_busy_a", j));
      expect_v(S_RDY_A, 8'h00, $sformatf("sweep%0d_ready_a", j));
      expect_v(S_BUSY_C, 8'h01, $sformatf("sweep%0d_busy_c", j));
      expect_v(S_RD0_A, old_v[j], $sformatf("sweep%0d_rd0_a", j));
      expect_v(S_RD1_A, (j == 0 || j == 10) ? old_v[15] : 8'h00, $sformatf("sweep%0d_rd1_a", j));
      expect_v(S_RD0_B, old_v[j], $sformatf("sweep%0d_rd0_b", j));
      expect_v(S_RD0_C, (j == 0) ? 8'h00 : old_v[j], $sformatf("sweep%0d_rd0_c", j));
      check_now();
      tick();
    end
    clr_req = 1'b0; we0 = 1'b0; ra0 = 4'd5; ra1 = 4'd15;
    expect_v(S_BUSY_A, 8'h00, "sweep_end_busy_a");
    expect_v(S_RDY_A, 8'h01, "sweep_end_ready_a");
    expect_v(S_RDY_C, 8'h01, "sweep_end_ready_c");
    expect_v(S_RD0_A, 8'h00, "sweep_end_rd0_a");
    expect_v(S_RD1_A, 8'h00, "sweep_end_dropped_wr_rd1_a");
    check_now();

    // Reset in the middle of a clear sweep.
    tick();
    we0 = 1'b1; wa0 = 4'd8; wd0 = 8'h88; we1 = 1'b1; wa1 = 4'd12; wd1 = 8'hCC;
    tick();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 1; j <= 5; j++) tick();
    ra0 = 4'd8; ra1 = 4'd12;
    expect_v(S_BUSY_A, 8'h01, "midclr_busy_a");
    expect_v(S_RD0_A, 8'h88, "midclr_rd0_a");
    expect_v(S_RD1_C, 8'hCC, "midclr_rd1_c");
    check_now();
    rst_n = 1'b0;
    expect_v(S_BUSY_A, 8'h00, "midrst_busy_a");
    expect_v(S_BUSY_C, 8'h00, "midrst_busy_c");
    expect_v(S_RDY_A, 8'h01, "midrst_ready_a");
    expect_v(S_RD0_A, 8'h00, "midrst_rd0_a");
    expect_v(S_RD1_C, 8'h00, "midrst_rd1_c");
    check_now();
    for (int a = 0; a < 16; a++) begin
      ra0 = 4'(a); ra1 = 4'(a);
      expect_v(S_RD0_A, 8'h00, $sformatf("midrst_rd0_a_%0d", a));
      expect_v(S_RD1_C, 8'h00, $sformatf("midrst_rd1_c_%0d", a));
      check_now();
    end

    // Reset release together with clr_req: the first live edge starts the clear.
    rst_n = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; ra0 = 4'd8;
    expect_v(S_BUSY_A, 8'h01, "release_clr_busy_a");
    expect_v(S_RDY_A, 8'h00, "release_clr_ready_a");
    expect_v(S_RD0_A, 8'h00, "release_rd0_a");
    check_now();

    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_queue: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file.
- Datapath storage for the CPU. Configurable width and depth; two write ports with fixed priority.
- Two asynchronous read ports with optional write-to-read bypass and an optional hardwired-zero register 0.
- Sequential clear engine that zeroes the array one entry per cycle without asserting reset.

Parameters:
- DATA_W, 8, register width in bits (>=1).
- DEPTH, 16, number of registers (>=2, power of two). Localparam ADDR_W = $clog2(DEPTH).
- BYPASS, 1, 1: a read of an address written this cycle returns the write data. 0: returns the stored value.
- R0_ZERO, 0, 1: register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra0  in  ADDR_W  read address, port 0
- rd0  out  DATA_W  read data, port 0 (combinational)
- ra1  in  ADDR_W  read address, port 1
- rd1  out  DATA_W  read data, port 1 (combinational)
- clr_req  in  1  request a sequential clear of all registers
- clr_busy  out  1  clear engine active
- wr_ready  out  1  writes accepted this cycle (= !clr_busy)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers go to 0, FSM goes to IDLE, clear counter goes to 0.
  - clr_busy=0, wr_ready=1.
  - rd0/rd1 return 0 for any address while reset is held.
- Writes:
  - Commit at posedge clk when weN=1 and wr_ready=1.
  - Writes presented while wr_ready=0 are dropped, not queued.
- Write collision: we0 and we1 both set with wa0==wa1 -> wd1 is stored and wd0 is discarded. Different addresses -> both commit in the same edge.
- R0_ZERO=1:
  - Writes to address 0 are discarded.
  - rd for address 0 is 0, with or without bypass.
- Reads: rdN = stored[raN], zero latency.
- BYPASS=1, wr_ready=1, and a write enable is active with address == raN -> rdN returns that write data. Port 1 data wins if both ports match. R0_ZERO still forces 0.
- BYPASS=0: reads return the pre-edge contents; a new value is visible the cycle after the write.
- Clear FSM, state IDLE:
  - clr_req=1 -> CLEAR on the next edge; counter=0.
  - Writes in that same cycle are accepted, because wr_ready is still 1.
- Clear FSM, state CLEAR:
  - Each edge zeroes entry[counter] and increments counter.
  - When counter==DEPTH-1 that entry is zeroed and the FSM returns to IDLE with counter=0.
  - Total duration is exactly DEPTH cycles with clr_busy=1.
  - clr_req is ignored in CLEAR; no re-trigger and no extension.
  - Reads stay live and return current stored contents; entries not yet swept keep their old values.
  - Bypass is inactive in CLEAR because no writes are accepted.
- clr_busy is a registered FSM decode: high from the edge that enters CLEAR to the edge that leaves it.
- Reset during CLEAR: immediate IDLE, all registers 0.
- Simultaneous reset release and clr_req: the first edge with rst_n=1 samples clr_req normally.
- All arithmetic is unsigned. The counter is ADDR_W bits and wraps only via the explicit DEPTH-1 compare.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every read is 0x00; clr_busy=0; wr_ready=1.
- Dual write, different addresses: we0 wa0=3 wd0=0x5A, we1 wa1=7 wd1=0xC3, one edge. Next cycle ra0=3 reads 0x5A, ra1=7 reads 0xC3.
- Write collision: both ports write address 9 (wd0=0x11, wd1=0x22) -> address 9 reads 0x22.
- Bypass, same cycle, ra0=wa1=4, wd1=0x99:
  - BYPASS=1 -> rd0=0x99 before the edge.
  - BYPASS=0 -> rd0 shows the old value, then 0x99 after the edge.
- Clear sweep:
  - Fill addresses 0..15 with value addr+0x10, then pulse clr_req for 1 cycle -> clr_busy high for exactly 16 cycles.
  - After k edges in CLEAR, addresses <k read 0 and addresses >=k read their old values.
  - A write of 0xFF to address 15 during CLEAR is dropped; address 15 reads 0 afterwards.
  - A clr_req during CLEAR does not extend clr_busy.
- R0_ZERO=1 and reset mid-clear:
  - Write 0xAB to address 0 -> reads 0.
  - Start a clear and drop rst_n at sweep cycle 5 -> clr_busy=0 immediately and all registers read 0.
